// File: rtl/lsu_pkg.sv
// Shared LSU definitions: memOp codes, FSM state codes, timeout default and op helpers.
// Used by the IDU/EXU as well as by load_store_unit and lsu_align.
package lsu_pkg;

    localparam int unsigned LSU_TIMEOUT_DEF = 255;
    localparam int unsigned LSU_LANES       = 4;

    typedef enum logic [2:0] {
        OP_NONE = 3'b000,
        OP_LW   = 3'b001,
        OP_LB   = 3'b010,
        OP_LBU  = 3'b011,
        OP_SW   = 3'b100,
        OP_SB   = 3'b101
    } memOp_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } lsuState_e;

    // Everything captured when an op is accepted in IDLE.
    typedef struct packed {
        memOp_e      op;
        logic [31:0] addr;
        logic [31:0] wData;
        logic [3:0]  be;
        logic [4:0]  rd;
    } lsuLatch_t;

    // The two unused codes collapse to NONE.
    function automatic memOp_e decodeOp(input logic [2:0] raw);
        case (raw)
            3'b001:  return OP_LW;
            3'b010:  return OP_LB;
            3'b011:  return OP_LBU;
            3'b100:  return OP_SW;
            3'b101:  return OP_SB;
            default: return OP_NONE;
        endcase
    endfunction

    function automatic logic isLoad(input memOp_e op);
        return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU);
    endfunction

    function automatic logic isStore(input memOp_e op);
        return (op == OP_SW) || (op == OP_SB);
    endfunction

    function automatic logic misaligned(input memOp_e op, input logic [1:0] lo);
        return ((op == OP_LW) || (op == OP_SW)) && (lo != 2'b00);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store replication and byte enables on the way out,
// load lane select with sign/zero extension on the way back.
module lsu_align
    import lsu_pkg::*;
(
    input  memOp_e      stOp,
    input  logic [1:0]  stLane,
    input  logic [31:0] stData,
    output logic [3:0]  stBe,
    output logic [31:0] stDataAl,
    input  memOp_e      ldOp,
    input  logic [1:0]  ldLane,
    input  logic [31:0] ldRaw,
    output logic [31:0] ldData
);
    logic [LSU_LANES-1:0][7:0] rawLanes;
    logic [LSU_LANES-1:0][7:0] stLanes;
    logic [7:0]                ldByte;

    assign rawLanes = ldRaw;
    assign stDataAl = stLanes;

    for (genvar i = 0; i < LSU_LANES; i++) begin : g_lane
        assign stBe[i]    = (stOp == OP_SB) ? (stLane == 2'(i)) : 1'b1;
        assign stLanes[i] = (stOp == OP_SB) ? stData[7:0] : stData[8*i +: 8];
    end

    assign ldByte = rawLanes[ldLane];

    always_comb begin
        ldData = ldRaw;
        case (ldOp)
            OP_LB:   ldData = {{24{ldByte[7]}}, ldByte};
            OP_LBU:  ldData = {24'h0, ldByte};
            default: ldData = ldRaw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: IDLE accepts, REQ waits for dm_ack, DONE writes back.
// Optional REQ watchdog with busErr is built only when LSU_TIMEOUT_EN is defined.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  memOp,
    input  logic [31:0] addr,
    input  logic [31:0] wData,
    input  logic        regcWr_i,
    input  logic [4:0]  regcAddr_i,
    input  logic [31:0] regcData_i,
    output logic        regcWr,
    output logic [4:0]  regcAddr,
    output logic [31:0] regcData,
    output logic        stall,
    output logic        dm_req,
    output logic        dm_we,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wData,
    input  logic        dm_ack,
    input  logic [31:0] dm_rData,
    output logic        addrErr,
    output logic        busErr
);
    lsuState_e   state;
    lsuLatch_t   lat;
    logic [31:0] ldQ;
    logic        wrQ;

    memOp_e      inOp;
    logic        inMem, inMis, accept, toFire;
    logic [3:0]  alBe;
    logic [31:0] alWData, alLd;

    assign inOp   = decodeOp(memOp);
    assign inMem  = (inOp != OP_NONE);
    assign inMis  = misaligned(inOp, addr[1:0]);
    assign accept = (state == ST_IDLE) && inMem && !inMis;

    // Store side steers the live inputs; load side uses the latched op and lane.
    lsu_align u_align (
        .stOp     (inOp),
        .stLane   (addr[1:0]),
        .stData   (wData),
        .stBe     (alBe),
        .stDataAl (alWData),
        .ldOp     (lat.op),
        .ldLane   (lat.addr[1:0]),
        .ldRaw    (dm_rData),
        .ldData   (alLd)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0] toCnt;
    logic          busErrQ;

    // toCnt holds the number of completed REQ cycles; fires on the last allowed one.
    assign toFire = (state == ST_REQ) && !dm_ack && (toCnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            toCnt   <= '0;
            busErrQ <= 1'b0;
        end else begin
            toCnt   <= (state == ST_REQ && !toFire && !dm_ack) ? toCnt + 1'b1 : '0;
            busErrQ <= toFire;
        end
    end
    assign busErr = busErrQ;
`else
    assign toFire = 1'b0;
    assign busErr = 1'b0;
    if (TIMEOUT_CYCLES == 0) begin : g_timeoutIgnored
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            lat   <= '0;
            ldQ   <= '0;
            wrQ   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat.op    <= inOp;
                        lat.addr  <= addr;
                        lat.wData <= alWData;
                        lat.be    <= alBe;
                        lat.rd    <= regcAddr_i;
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (dm_ack) begin
                        ldQ   <= alLd;
                        wrQ   <= isLoad(lat.op);
                        state <= ST_DONE;
                    end else if (toFire) begin
                        wrQ   <= 1'b0;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    wrQ   <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign dm_req   = (state == ST_REQ);
    assign dm_we    = (state == ST_REQ) && isStore(lat.op);
    assign dm_be    = (state == ST_REQ) ? lat.be : 4'b0000;
    assign dm_addr  = lat.addr;
    assign dm_wData = lat.wData;

    // Accept-cycle stall and the misaligned pulse must be visible in the same cycle.
    always_comb begin
        regcWr   = 1'b0;
        regcAddr = regcAddr_i;
        regcData = regcData_i;
        stall    = 1'b0;
        addrErr  = 1'b0;
        if (!rst) begin
            case (state)
                ST_IDLE: begin
                    if (!inMem)     regcWr  = regcWr_i;
                    else if (inMis) addrErr = 1'b1;
                    else            stall   = 1'b1;
                end
                ST_REQ:  stall = 1'b1;
                ST_DONE: begin
                    regcWr   = wrQ;
                    regcAddr = lat.rd;
                    regcData = ldQ;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, hand sequences for
// reset/ack corner cases, and random ops checked against a byte-arithmetic model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  memOp;
    logic [31:0] addr, wData;
    logic        regcWr_i;
    logic [4:0]  regcAddr_i;
    logic [31:0] regcData_i;
    logic        regcWr;
    logic [4:0]  regcAddr;
    logic [31:0] regcData;
    logic        stall, dm_req, dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr, dm_wData;
    logic        dm_ack;
    logic [31:0] dm_rData;
    logic        addrErr, busErr;

    int nVec = 0;
    int nBad = 0;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .memOp(memOp), .addr(addr), .wData(wData),
        .regcWr_i(regcWr_i), .regcAddr_i(regcAddr_i), .regcData_i(regcData_i),
        .regcWr(regcWr), .regcAddr(regcAddr), .regcData(regcData), .stall(stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wData(dm_wData), .dm_ack(dm_ack), .dm_rData(dm_rData),
        .addrErr(addrErr), .busErr(busErr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [1:0]  ackDly;
        logic        eErr;
        logic [3:0]  eBe;
        logic [31:0] eWData;
        logic        eWe;
        logic        eWr;
        logic [31:0] eData;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: the memory-op rules written as plain byte arithmetic.
    function automatic bit mIsMem(input int op);   return op >= 1 && op <= 5; endfunction
    function automatic bit mIsStore(input int op); return op == 4 || op == 5; endfunction
    function automatic bit mErr(input int op, input logic [31:0] a);
        return (op == 1 || op == 4) && (a % 4 != 0);
    endfunction
    function automatic logic [3:0] mBe(input int op, input logic [31:0] a);
        return (op == 5) ? 4'(1 << (a % 4)) : 4'hF;
    endfunction
    function automatic logic [31:0] mWData(input int op, input logic [31:0] wd);
        return (op == 5) ? (wd & 32'hFF) * 32'h01010101 : wd;
    endfunction
    function automatic logic [31:0] mLoad(input int op, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] b;
        b = (rd >> (8 * (a % 4))) & 32'hFF;
        if (op == 1) return rd;
        if (op == 2 && b >= 128) return b + 32'hFFFFFF00;
        return b;
    endfunction

    // Runs one op starting just after a posedge with the unit in IDLE.
    task automatic apply(input string tag, input vec_t v);
        logic [4:0]  rA;
        rA         = 5'($urandom);
        memOp      = v.op;
        addr       = v.a;
        wData      = v.wd;
        regcWr_i   = 1'b1;
        regcAddr_i = rA;
        regcData_i = $urandom;
        dm_ack     = 1'b0;
        @(negedge clk);
        chk({tag, " addrErr"}, addrErr, v.eErr);
        chk({tag, " acceptWr"}, regcWr, 1'b0);
        if (v.eErr) begin
            chk({tag, " errStall"}, stall, 1'b0);
            @(posedge clk); #1;
            memOp = 3'b000;
            @(negedge clk);
            chk({tag, " errNoReq"}, dm_req, 1'b0);
            @(posedge clk); #1;
            return;
        end
        chk({tag, " acceptStall"}, stall, 1'b1);
        @(posedge clk); #1;
        for (int c = 0; c <= int'(v.ackDly); c++) begin
            dm_ack   = (c == int'(v.ackDly));
            dm_rData = dm_ack ? v.rd : $urandom;
            @(negedge clk);
            chk({tag, " dm_req"}, dm_req, 1'b1);
            chk({tag, " reqStall"}, stall, 1'b1);
            chk({tag, " dm_addr"}, dm_addr, v.a);
            chk({tag, " dm_be"}, dm_be, v.eBe);
            chk({tag, " dm_we"}, dm_we, v.eWe);
            if (v.eWe) chk({tag, " dm_wData"}, dm_wData, v.eWData);
            @(posedge clk); #1;
        end
        dm_ack     = 1'b1;
        memOp      = 3'b001;
        regcWr_i   = 1'b0;
        @(negedge clk);
        chk({tag, " doneStall"}, stall, 1'b0);
        chk({tag, " doneReq"}, dm_req, 1'b0);
        chk({tag, " regcWr"}, regcWr, v.eWr);
        if (v.eWr) begin
            chk({tag, " regcAddr"}, regcAddr, rA);
            chk({tag, " regcData"}, regcData, v.eData);
        end
        @(posedge clk); #1;
        dm_ack = 1'b0;
        memOp  = 3'b000;
    endtask

    vec_t tbl[10];

    initial begin
        vec_t v;
        int   op, n;
        rst = 1'b1; memOp = '0; addr = '0; wData = '0;
        regcWr_i = 1'b1; regcAddr_i = 5'd7; regcData_i = 32'h1234; dm_ack = 1'b0; dm_rData = '0;

        tbl[0] = '{3'b001, 32'h100, 32'h0,        32'hDEADBEEF, 2'd0, 1'b0, 4'hF, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
        tbl[1] = '{3'b010, 32'h103, 32'h0,        32'h80112233, 2'd1, 1'b0, 4'hF, 32'h0,        1'b0, 1'b1, 32'hFFFFFF80};
        tbl[2] = '{3'b011, 32'h103, 32'h0,        32'h80112233, 2'd0, 1'b0, 4'hF, 32'h0,        1'b0, 1'b1, 32'h00000080};
        tbl[3] = '{3'b101, 32'h102, 32'h000000A5, 32'h0,        2'd0, 1'b0, 4'b0100, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h0};
        tbl[4] = '{3'b100, 32'h101, 32'h0,        32'h0,        2'd0, 1'b1, 4'hF, 32'h0,        1'b0, 1'b0, 32'h0};
        tbl[5] = '{3'b100, 32'h200, 32'h12345678, 32'h0,        2'd2, 1'b0, 4'hF, 32'h12345678, 1'b1, 1'b0, 32'h0};
        tbl[6] = '{3'b010, 32'h101, 32'h0,        32'h00007F00, 2'd3, 1'b0, 4'hF, 32'h0,        1'b0, 1'b1, 32'h0000007F};
        tbl[7] = '{3'b001, 32'h102, 32'h0,        32'h0,        2'd0, 1'b1, 4'hF, 32'h0,        1'b0, 1'b0, 32'h0};
        tbl[8] = '{3'b011, 32'h100, 32'h0,        32'hFFFFFFFE, 2'd1, 1'b0, 4'hF, 32'h0,        1'b0, 1'b1, 32'h000000FE};
        tbl[9] = '{3'b101, 32'h103, 32'h123456C3, 32'h0,        2'd0, 1'b0, 4'b1000, 32'hC3C3C3C3, 1'b1, 1'b0, 32'h0};

        // Reset state, with a writeback request held on the inputs.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst regcWr", regcWr, 1'b0);
        chk("rst stall", stall, 1'b0);
        chk("rst dm_req", dm_req, 1'b0);
        chk("rst dm_be", dm_be, 4'h0);
        chk("rst busErr", busErr, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // IDLE passthrough, ack outside REQ ignored.
        dm_ack = 1'b1; regcWr_i = 1'b1; regcAddr_i = 5'd0; regcData_i = 32'hCAFEF00D;
        @(negedge clk);
        chk("pass regcWr", regcWr, 1'b1);
        chk("pass regcAddr0", regcAddr, 5'd0);
        chk("pass regcData", regcData, 32'hCAFEF00D);
        @(posedge clk); #1;
        dm_ack = 1'b0;
        @(negedge clk);
        chk("strayAck req", dm_req, 1'b0);
        chk("strayAck stall", stall, 1'b0);
        @(posedge clk); #1;

        foreach (tbl[i]) apply($sformatf("tbl%0d", i), tbl[i]);

        // Reset in the 3rd REQ cycle of a load that never gets its ack.
        memOp = 3'b001; addr = 32'h300; regcWr_i = 1'b1; regcAddr_i = 5'd5; dm_ack = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("rstMid inReq", dm_req, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstMid stall", stall, 1'b0);
        chk("rstMid regcWr", regcWr, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0; memOp = 3'b000; regcWr_i = 1'b0; dm_ack = 1'b1;
        @(negedge clk);
        chk("rstMid dm_req", dm_req, 1'b0);
        chk("rstMid stallAfter", stall, 1'b0);
        @(posedge clk); #1;
        dm_ack = 1'b0;
        @(negedge clk);
        chk("rstMid noWb", regcWr, 1'b0);
        chk("rstMid idle", dm_req, 1'b0);
        @(posedge clk); #1;

`ifdef LSU_TIMEOUT_EN
        memOp = 3'b001; addr = 32'h400; regcWr_i = 1'b1; dm_ack = 1'b0;
        @(posedge clk); #1;
        n = 0;
        while (dm_req && n < 20) begin n++; @(posedge clk); #1; end
        memOp = 3'b000;
        chk("to reqCycles", 32'(n), 32'd4);
        chk("to busErr", busErr, 1'b1);
        chk("to regcWr", regcWr, 1'b0);
        chk("to stall", stall, 1'b0);
        @(posedge clk); #1;
        chk("to busErrPulse", busErr, 1'b0);
`endif

        // Random ops against the model.
        for (int k = 0; k < 60; k++) begin
            op = $urandom_range(0, 7);
            v.op = 3'(op);
            v.a  = $urandom;
            if ((op == 1 || op == 4) && $urandom_range(0, 3) != 0) v.a[1:0] = 2'b00;
            v.wd = $urandom; v.rd = $urandom; v.ackDly = 2'($urandom);
            if (!mIsMem(op)) begin
                memOp = v.op; addr = v.a; regcWr_i = 1'($urandom);
                regcAddr_i = 5'($urandom); regcData_i = $urandom; dm_ack = 1'($urandom);
                @(negedge clk);
                chk("rnd passWr", regcWr, regcWr_i);
                chk("rnd passData", regcData, regcData_i);
                chk("rnd passStall", stall, 1'b0);
                @(posedge clk); #1;
                dm_ack = 1'b0; memOp = 3'b000;
                @(negedge clk);
                chk("rnd passNoReq", dm_req, 1'b0);
                @(posedge clk); #1;
            end else begin
                v.eErr   = mErr(op, v.a);
                v.eBe    = mBe(op, v.a);
                v.eWData = mWData(op, v.wd);
                v.eWe    = mIsStore(op);
                v.eWr    = !mIsStore(op);
                v.eData  = mLoad(op, v.a, v.rd);
                apply($sformatf("rnd%0d", k), v);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the maximum REQ cycles without dm_ack before abort (only with LSU_TIMEOUT_EN).
REQ-002 clk  in  1  single clock; all state SHALL update on posedge clk.
REQ-003 rst  in  1  reset; SHALL be synchronous and active-high.
REQ-004 memOp  in  3  from EXU: 000 NONE, 001 LW, 010 LB, 011 LBU, 100 SW, 101 SB; other codes SHALL be treated as NONE.
REQ-005 addr  in  32  effective address from EXU regcData.
REQ-006 wData  in  32  store data.
REQ-007 regcWr_i / regcAddr_i / regcData_i  in  1/5/32  EXU writeback signals.
REQ-008 regcWr / regcAddr / regcData  out  1/5/32  writeback to RegFile.
REQ-009 stall  out  1  freezes IFU/IDU/EXU; upstream holds inputs while high.
REQ-010 dm_req / dm_we / dm_be / dm_addr / dm_wData  out  1/1/4/32/32  data-memory request.
REQ-011 dm_ack / dm_rData  in  1/32  memory completion and read data (valid with ack).
REQ-012 addrErr / busErr  out  1/1  single-cycle error pulses.

Function
REQ-013 FSM states IDLE, REQ, DONE SHALL be encoded as in the shared package.
REQ-014 IDLE, memOp NONE: regcWr/regcAddr/regcData SHALL be combinational passthrough of the *_i inputs; stall=0.
REQ-015 IDLE, memory op, aligned: stall=1 combinationally; addr, op, aligned wData, dm_be, regcAddr_i SHALL be latched; next state REQ.
REQ-016 Alignment: LW/SW SHALL require addr[1:0]=00; byte ops always aligned.
REQ-017 IDLE, misaligned: no request; addrErr=1 for that cycle; regcWr=0; stall=0; state stays IDLE.
REQ-018 REQ: dm_req=1 and dm_addr/dm_we/dm_be/dm_wData SHALL hold the latched values; stall=1.
REQ-019 dm_be: LW/LB/LBU SHALL drive 1111; SW 1111; SB 1<<addr[1:0], with wData[7:0] replicated to all four lanes.
REQ-020 dm_ack in REQ, including the first REQ cycle, SHALL capture load data and move to DONE; dm_ack outside REQ SHALL be ignored.
REQ-021 Load data: LW full word; LB sign-extended lane addr[1:0]; LBU zero-extended lane.
REQ-022 DONE: stall=0; loads SHALL drive regcWr=1 with latched regcAddr and captured data for exactly one cycle; stores regcWr=0; inputs ignored; next state IDLE.
REQ-023 Minimum latency SHALL be 3 cycles for a memory op (accept, REQ with ack, DONE), with stall high for 2 cycles.
REQ-024 Writes to regcAddr 0 SHALL pass through unchanged; RegFile discards them.

Reset
REQ-025 rst SHALL force IDLE, clear latches, timeout counter, dm_req, dm_we, dm_be, addrErr and busErr to 0 at the next edge, including mid-REQ; no writeback for the aborted op.
REQ-026 During rst, stall=0 and regcWr=0.

Configuration
REQ-027 With LSU_TIMEOUT_EN defined, an 8-bit+ counter SHALL count REQ cycles. At TIMEOUT_CYCLES without ack, the unit SHALL drop dm_req, pulse busErr, go to DONE with regcWr=0.
REQ-028 Without LSU_TIMEOUT_EN, no counter SHALL exist; REQ waits indefinitely; busErr SHALL be tied 0.

Structure
REQ-029 Package lsu_pkg SHALL hold the memOp encodings, FSM state encodings and the default TIMEOUT_CYCLES constant, shared with IDU/EXU.
REQ-030 Combinational sub-module lsu_align SHALL perform store lane replication, dm_be generation and load lane select/extension.

Verification
REQ-031 LW addr=0x100, ack first REQ cycle, rData=0xDEADBEEF -> stall 2 cycles; regcWr=1 with data 0xDEADBEEF for one cycle.
REQ-032 LB addr=0x103, rData=0x80112233 -> regcData=0xFFFFFF80; LBU same -> 0x00000080.
REQ-033 SB addr=0x102, wData=0x000000A5 -> dm_be=0100, dm_wData=0xA5A5A5A5, dm_we=1, regcWr=0.
REQ-034 SW addr=0x101 -> addrErr pulse, dm_req stays 0, stall 0.
REQ-035 LW with ack withheld, rst asserted in the 3rd REQ cycle -> dm_req=0 next edge, IDLE, no writeback.
REQ-036 LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> busErr pulse after 4 REQ cycles, regcWr stays 0, stall released.
